// File: rtl/pin_route_sequencer.sv
// pin_route_sequencer
// Break-before-make sequencer for the board pin routing multiplexers.
// A change on sel[g] puts pin group g into high-Z (guard), waits GUARD_CYCLES,
// flips route[g], waits SETTLE_CYCLES, then releases the group. One shared
// sequencer serves the four groups in round-robin order.
//
// Optional feature macro: PIN_ROUTE_SEQ_LOCK_EN
//   When defined, a pending group is only granted while the core drives none
//   of its pins (pin_dir & GROUPn_MASK == 0). When undefined, pin_dir is unused.
module pin_route_sequencer #(
  parameter logic [15:0] GUARD_CYCLES  = 16'd64,
  parameter logic [15:0] SETTLE_CYCLES = 16'd16,
  parameter logic [31:0] GROUP0_MASK   = 32'h0F00_0000,
  parameter logic [31:0] GROUP1_MASK   = 32'h00FF_0000,
  parameter logic [31:0] GROUP2_MASK   = 32'h0000_0400,
  parameter logic [31:0] GROUP3_MASK   = 32'hC000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  sel,
  input  logic [31:0] pin_dir,
  output logic [3:0]  route,
  output logic [3:0]  guard,
  output logic [31:0] pin_force_z,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    APPLY  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  cur;
  logic [1:0]  rr;
  logic [15:0] cnt;

  logic [3:0]  pending;
  logic [3:0]  eligible;
  logic        grant_vld;
  logic [1:0]  grant_grp;

  // Pin mask belonging to a group index.
  function automatic logic [31:0] group_mask(input logic [1:0] g);
    logic [31:0] m;
    case (g)
      2'd0:    m = GROUP0_MASK;
      2'd1:    m = GROUP1_MASK;
      2'd2:    m = GROUP2_MASK;
      default: m = GROUP3_MASK;
    endcase
    return m;
  endfunction

  // First requesting group scanning start, start+1, start+2, start+3 (mod 4).
  // Returns {valid, group}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic       found;
    logic [1:0] grp;
    logic [1:0] idx;
    found = 1'b0;
    grp   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = start + i[1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        grp   = idx;
      end
    end
    return {found, grp};
  endfunction

  // A group is pending whenever its requested and applied routes differ.
  assign pending = sel ^ route;

`ifdef PIN_ROUTE_SEQ_LOCK_EN
  // Hold off a group while the core still drives any of its pins.
  always_comb begin
    eligible = '0;
    for (int g = 0; g < 4; g++) begin
      eligible[g] = pending[g] && ((pin_dir & group_mask(g[1:0])) == 32'h0);
    end
  end
`else
  // Every pending group may be granted; pin direction plays no part.
  logic unused_pin_dir;
  assign unused_pin_dir = ^pin_dir;
  always_comb begin
    eligible = pending;
  end
`endif

  // Round-robin arbitration among eligible groups, starting at rr.
  always_comb begin
    {grant_vld, grant_grp} = rr_pick(eligible, rr);
  end

  // Pins of the guarded group are forced to high-Z.
  always_comb begin
    pin_force_z = 32'h0;
    for (int g = 0; g < 4; g++) begin
      if (guard[g]) pin_force_z = pin_force_z | group_mask(g[1:0]);
    end
  end

  // Sequencer FSM: grant, drain, apply route, settle, release.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cur   <= 2'd0;
      rr    <= 2'd0;
      cnt   <= 16'd0;
      route <= 4'b0000;
      guard <= 4'b0000;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            cur   <= grant_grp;
            guard <= 4'b0001 << grant_grp;
            cnt   <= GUARD_CYCLES - 16'd1;
            busy  <= 1'b1;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt == 16'd0) begin
            state <= APPLY;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        APPLY: begin
          // sel is sampled here; if it reverted during DRAIN this is a no-op.
          route[cur] <= sel[cur];
          cnt        <= SETTLE_CYCLES - 16'd1;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (cnt == 16'd0) begin
            guard <= 4'b0000;
            rr    <= cur + 2'd1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          guard <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Only one group may be in high-Z at a time.
  guard_onehot_a: assert property (@(posedge clock) disable iff (reset) $onehot0(guard));
  // busy mirrors the non-IDLE state.
  busy_state_a: assert property (@(posedge clock) disable iff (reset) busy == (state != IDLE));
`endif

endmodule

// File: tb/tb_pin_route_sequencer.sv
// Directed testbench for pin_route_sequencer (GUARD=64, SETTLE=16).
// Build with +define+PIN_ROUTE_SEQ_LOCK_EN to exercise the pin-lock variant.
module tb_pin_route_sequencer;

  logic        clock;
  logic        reset;
  logic [3:0]  sel;
  logic [31:0] pin_dir;
  logic [3:0]  route;
  logic [3:0]  guard;
  logic [31:0] pin_force_z;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  pin_route_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .sel         (sel),
    .pin_dir     (pin_dir),
    .route       (route),
    .guard       (guard),
    .pin_force_z (pin_force_z),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] s);
    reset = 1'b1;
    sel   = s;
    step();
    step();
    reset = 1'b0;
  endtask

  // Wait for a grant, then follow the sequence until guard drops.
  // gidx: granted group, hi: cycles guard was high, rdelay: cycles from guard
  // rising to route change (-1 if route never changed), multi: guard multi-hot.
  // If revert_at >= 0, sel is overwritten with revert_sel after that sample.
  task automatic run_seq(input int revert_at, input logic [3:0] revert_sel,
                         output int gidx, output int hi, output int rdelay, output bit multi);
    int         waitc;
    int         k;
    logic [3:0] r0;
    waitc  = 0;
    gidx   = -1;
    hi     = 0;
    rdelay = -1;
    multi  = 1'b0;
    while (guard == 4'b0 && waitc < 300) begin
      step();
      waitc++;
    end
    if (guard == 4'b0) begin
      chk("grant_timeout", {31'b0, guard != 4'b0}, 32'd1);
      return;
    end
    for (int g = 0; g < 4; g++) if (guard[g]) gidx = g;
    r0 = route;
    k  = 0;
    while (guard != 4'b0 && hi < 1000) begin
      if ($countones(guard) > 1) multi = 1'b1;
      if (rdelay < 0 && route != r0) rdelay = k;
      if (k == revert_at) sel = revert_sel;
      hi++;
      step();
      k++;
    end
    chk("busy_after_seq", {31'b0, busy}, 32'd0);
  endtask

  // Count grants over a window (busy rising edges) with sel steady.
  task automatic idle_window(input int cycles, output int starts);
    logic prev;
    starts = 0;
    prev   = busy;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (busy && !prev) starts++;
      prev = busy;
    end
  endtask

  int gi, hi, rd, ns;
  bit mh;

  initial begin
    reset   = 1'b1;
    sel     = 4'b0;
    pin_dir = 32'h0;

    // ---------------- Test 1: single group 1 sequence ----------------
    step();
    step();
    chk("rst_route", {28'b0, route}, 32'h0);
    chk("rst_guard", {28'b0, guard}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_force_z", pin_force_z, 32'h0);
    reset = 1'b0;
    step();
    chk("idle_busy", {31'b0, busy}, 32'h0);
    sel = 4'b0010;
    step();  // grant edge
    chk("t1_guard", {28'b0, guard}, 32'h2);
    chk("t1_force_z", pin_force_z, 32'h00FF_0000);
    chk("t1_busy", {31'b0, busy}, 32'h1);
    repeat (64) step();
    chk("t1_route_before", {28'b0, route}, 32'h0);
    step();
    chk("t1_route_after65", {28'b0, route}, 32'h2);
    repeat (15) step();
    chk("t1_guard_at80", {28'b0, guard}, 32'h2);
    step();
    chk("t1_guard_at81", {28'b0, guard}, 32'h0);
    chk("t1_busy_end", {31'b0, busy}, 32'h0);
    chk("t1_force_z_end", pin_force_z, 32'h0);

    // ---------------- Test 2: all four groups, round robin ----------------
    do_reset(4'b0000);
    sel = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      run_seq(-1, 4'b0, gi, hi, rd, mh);
      chk($sformatf("t2_grp%0d", s), gi, s);
      chk($sformatf("t2_hi%0d", s), hi, 81);
      chk($sformatf("t2_rdly%0d", s), rd, 65);
      chk($sformatf("t2_multi%0d", s), {31'b0, mh}, 32'h0);
    end
    chk("t2_route", {28'b0, route}, 32'hF);
    idle_window(200, ns);
    chk("t2_extra_seq", ns, 0);

    // ---------------- Test 3: sel[3] reverts during DRAIN ----------------
    do_reset(4'b0000);
    sel = 4'b1000;
    run_seq(5, 4'b0000, gi, hi, rd, mh);
    chk("t3_grp", gi, 3);
    chk("t3_hi", hi, 81);
    chk("t3_no_route_change", rd, -1);
    chk("t3_route", {28'b0, route}, 32'h0);
    idle_window(200, ns);
    chk("t3_extra_seq", ns, 0);

    // ---------------- Test 4: reset during SETTLE of group 2 ----------------
    do_reset(4'b0000);
    sel = 4'b0100;
    begin
      int waitc;
      waitc = 0;
      while (guard == 4'b0 && waitc < 300) begin
        step();
        waitc++;
      end
    end
    chk("t4_guard", {28'b0, guard}, 32'h4);
    chk("t4_force_z", pin_force_z, 32'h0000_0400);
    repeat (65) step();
    chk("t4_route_set", {28'b0, route}, 32'h4);
    reset = 1'b1;
    step();
    chk("t4_rst_route", {28'b0, route}, 32'h0);
    chk("t4_rst_guard", {28'b0, guard}, 32'h0);
    chk("t4_rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    run_seq(-1, 4'b0, gi, hi, rd, mh);
    chk("t4_regrp", gi, 2);
    chk("t4_rerdly", rd, 65);
    chk("t4_reroute", {28'b0, route}, 32'h4);

    // ---------------- Test 5: pin_dir lock ----------------
    do_reset(4'b0000);
    pin_dir = 32'h0000_0400;
    sel     = 4'b0101;
    run_seq(-1, 4'b0, gi, hi, rd, mh);
    chk("t5_first_grp", gi, 0);
`ifdef PIN_ROUTE_SEQ_LOCK_EN
    idle_window(200, ns);
    chk("t5_locked_seq", ns, 0);
    chk("t5_locked_route", {28'b0, route}, 32'h1);
    pin_dir = 32'h0;
`endif
    run_seq(-1, 4'b0, gi, hi, rd, mh);
    chk("t5_second_grp", gi, 2);
    chk("t5_route", {28'b0, route}, 32'h5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pin_route_sequencer.md
# pin_route_sequencer

Break-before-make sequencer for the board-level pin routing multiplexers. It sits between the switch debouncer (`switch_db[15:12]`) and the top-level route multiplexers.

- **Today:** a debounced switch edge re-steers Propeller pins between onboard peripherals and PMOD headers immediately, and both sides can drive at once.
- **With this block:** the affected pin group is forced to high-Z, the route bit changes, and the pins stay high-Z through a settle interval before release.
- When several switches change together, one shared sequencer serves the groups in round-robin order.

## Interface
Parameters:
- `GUARD_CYCLES`, default 16'd64: high-Z cycles before the route bit changes. Legal range 1..65535.
- `SETTLE_CYCLES`, default 16'd16: high-Z cycles after the route bit changes. Legal range 1..65535.
- `GROUP0_MASK`, default 32'h0F00_0000: pins 24-27 (PS2 / pmodD select, sw12).
- `GROUP1_MASK`, default 32'h00FF_0000: pins 16-23 (VGA / pmodC select, sw13).
- `GROUP2_MASK`, default 32'h0000_0400: pin 10 (amp / pmodB select, sw14).
- `GROUP3_MASK`, default 32'hC000_0000: pins 30-31 (USB UART / Prop Plug select, sw15).

Ports:
- `clock`, input, 1: single clock, same domain as the debouncer (`slow_clk`).
- `reset`, input, 1: synchronous, active-high.
- `sel`, input, 4: requested route per group, from `switch_db[15:12]`.
- `pin_dir`, input, 32: core pin direction bus.
- `route`, output, 4: applied route select that drives the multiplexers.
- `guard`, output, 4: group is currently forced to high-Z.
- `pin_force_z`, output, 32: OR of the `GROUPn_MASK` values for every set `guard` bit. The top level ANDs each output enable with the inverse of this bit.
- `busy`, output, 1: high when the state machine is not in IDLE.

## Operation
- **Pending:** `pending[g] = sel[g] ^ route[g]`.
- **States:** IDLE, DRAIN, APPLY, SETTLE. Registers are `state`, `cur` (2-bit active group), `rr` (2-bit round-robin pointer) and a 16-bit down-counter `cnt`.
- **IDLE:** if any `pending` bit is set, grant the first pending group scanning `rr`, `rr+1`, `rr+2`, `rr+3` (mod 4).
  - Load `cur` with that group.
  - Set `guard[cur]`.
  - Load `cnt` with `GUARD_CYCLES-1`.
  - Go to DRAIN.
- **DRAIN:** decrement `cnt`. When `cnt==0`, go to APPLY.
- **APPLY:** one cycle.
  - `route[cur] <= sel[cur]`, sampled in this cycle.
  - Load `cnt` with `SETTLE_CYCLES-1`.
  - Go to SETTLE.
- **SETTLE:** decrement `cnt`. When `cnt==0`:
  - Clear `guard[cur]`.
  - Set `rr <= cur+1`.
  - Go to IDLE.
- Only one group is guarded at a time, so `guard` is one-hot or zero.
- **`sel[cur]` reverts during DRAIN:** the sequence still runs to completion. APPLY writes the current `sel`, which is a no-op on `route`. Guard timing is unchanged.
- **`sel` changes for a non-active group:** the request stays pending and is served in a later grant. No request is lost or duplicated.
- `pin_dir` is ignored unless the `PIN_ROUTE_SEQ_LOCK_EN` macro is defined (see Configuration).
- **Reset values:** `route=4'b0000` (default onboard routes), `guard=0`, `pin_force_z=0`, `busy=0`, `state=IDLE`, `rr=0`, `cnt=0`.
  - If `sel` is nonzero when reset deasserts, those groups are pending and are sequenced normally.

## Timing
- All outputs are registered except `pin_force_z`, which is combinational from `guard` and the masks.
- **Grant:** a grant decided in IDLE at edge N makes `guard` and `busy` visible after edge N.
- **Route change:** `route[cur]` changes at the edge that ends APPLY, exactly `GUARD_CYCLES+1` cycles after `guard` rises.
- **Guard duration:** `guard` is high for `GUARD_CYCLES+1+SETTLE_CYCLES` cycles.
- **Between sequences:** at least one IDLE cycle with `busy=0` separates consecutive sequences.
- **Reset during any state:** takes effect at the next edge, with all outputs at their reset values. A half-applied route reverts to 0.

## Configuration
- **Macro `PIN_ROUTE_SEQ_LOCK_EN` defined:** in IDLE, a pending group g is eligible only if `(pin_dir & GROUPn_MASK)==0` for that group.
  - The round-robin scan skips ineligible groups.
  - An ineligible group stays pending indefinitely until the core releases its pins.
- **Macro not defined:** every pending group is eligible regardless of `pin_dir`.

## Test plan
1. Reset with `sel=0`, then set `sel=4'b0010` (GUARD=64, SETTLE=16):
   - `guard=4'b0010` and `pin_force_z=32'h00FF_0000` the cycle after the grant.
   - `route[1]` becomes 1 after 65 cycles.
   - `guard` clears after 81 cycles, then `busy=0`.
2. Set `sel=4'b1111` in one cycle from `route=0`:
   - Groups are served in order 0, 1, 2, 3.
   - `guard` is never multi-hot.
   - Final `route=4'b1111`, with exactly 4 sequences.
3. Toggle `sel[3]` 1 then 0 while group 3 is in DRAIN:
   - `route[3]` stays 0.
   - The full 81-cycle guard is still observed.
   - No second sequence starts.
4. Assert `reset` during SETTLE of group 2 (route just set to 1):
   - Next cycle shows `route=0`, `guard=0`, `busy=0`.
   - After release with `sel[2]=1`, a new sequence re-applies `route[2]=1`.
5. Build with `PIN_ROUTE_SEQ_LOCK_EN`, `pin_dir=32'h0000_0400`, `sel=4'b0101`:
   - Group 0 is sequenced.
   - Group 2 stays pending with `route[2]=0` until `pin_dir[10]` falls, then it is sequenced.
   - Without the macro, both groups are sequenced immediately.
